// File: rtl/mem_arbiter.sv
// Shares one RAM port between the bus controller data channel and two icache
// fetch ports. Data has priority, and a saturating counter forces a fetch
// after STARVE_LIMIT back-to-back data grants while any fetch is waiting.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  // bus controller side
  input  logic             bus_dREN,
  input  logic             bus_dWEN,
  input  logic [31:0]      bus_daddr,
  input  logic [31:0]      bus_dstore,
  output logic [31:0]      bus_dload,
  output logic             bus_dwait,
  // icache side
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [31:0]      iload,
  output logic [1:0]       iwait,
  // RAM side
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  // debug visibility of the arbitration state
  output logic [1:0]       dbg_state_o,
  output logic             dbg_rr_o,
  output logic [2:0]       dbg_scnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    INSTR0 = 2'd2,
    INSTR1 = 2'd3
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [2:0] LIMIT = (STARVE_LIMIT > 7) ? 3'd7 : 3'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       rr_q, rr_d;
  logic [2:0] scnt_q, scnt_d;

  logic   d_req;
  logic   i_any;
  logic   ram_done;
  logic   gnt_idx;
  state_t i_pick;

  assign d_req    = bus_dREN | bus_dWEN;
  assign i_any    = |iREN;
  assign ram_done = (ramstate == RAM_ACCESS);
  assign gnt_idx  = (state_q == INSTR1);
  assign i_pick   = ((iREN == 2'b10) || ((iREN == 2'b11) && rr_q)) ? INSTR1 : INSTR0;

  // Handshake: a requester holds its request until its wait goes low for one
  // cycle; dropping the request early aborts the access with no wait pulse.
  // Strobes follow the request combinationally so an abort is seen at once.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    scnt_d    = scnt_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    bus_dload = '0;
    iload     = '0;
    bus_dwait = 1'b1;
    iwait     = 2'b11;

    case (state_q)
      IDLE: begin
        if ((scnt_q == LIMIT) && i_any) begin
          state_d = i_pick;
        end else if (d_req) begin
          state_d = DATA;
        end else if (i_any) begin
          state_d = i_pick;
        end
      end

      DATA: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr   = bus_daddr;
          bus_dload = ramload;
          if (bus_dWEN) begin
            ramWEN   = 1'b1;
            ramstore = bus_dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ram_done) begin
            bus_dwait = 1'b0;
            state_d   = IDLE;
            if (i_any) begin
              scnt_d = (scnt_q >= LIMIT) ? LIMIT : scnt_q + 3'd1;
            end else begin
              scnt_d = '0;
            end
          end
        end
      end

      INSTR0, INSTR1: begin
        if (!iREN[gnt_idx]) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[gnt_idx];
          iload   = ramload;
          if (ram_done) begin
            iwait[gnt_idx] = 1'b0;
            rr_d           = ~gnt_idx;
            scnt_d         = '0;
            state_d        = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      scnt_q  <= scnt_d;
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_rr_o    = rr_q;
  assign dbg_scnt_o  = scnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM with programmable latency/ERROR
// phase, an expected-completion queue checked on every wait pulse, and
// directed scenarios for priority, round-robin, starvation, abort and reset.
module tb_mem_arbiter;

  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             bus_dREN, bus_dWEN;
  logic [31:0]      bus_daddr, bus_dstore, bus_dload;
  logic             bus_dwait;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [31:0]      iload;
  logic [1:0]       iwait;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;
  logic [1:0]       dbg_state_o;
  logic             dbg_rr_o;
  logic [2:0]       dbg_scnt_o;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .bus_dREN(bus_dREN), .bus_dWEN(bus_dWEN), .bus_daddr(bus_daddr),
    .bus_dstore(bus_dstore), .bus_dload(bus_dload), .bus_dwait(bus_dwait),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .dbg_state_o(dbg_state_o), .dbg_rr_o(dbg_rr_o), .dbg_scnt_o(dbg_scnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:4095];
  int          lat;
  bit          err_mode;
  int          cnt;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  end

  assign ramload = mem[ramaddr[11:0]];

  always_comb begin
    if (!(ramREN || ramWEN))      ramstate = R_FREE;
    else if (cnt >= lat)          ramstate = R_ACC;
    else if (err_mode)            ramstate = R_ERR;
    else                          ramstate = R_BUSY;
  end

  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && ramstate != R_ACC) cnt <= cnt + 1;
    else cnt <= 0;
    if (ramWEN && ramstate == R_ACC) mem[ramaddr[11:0]] <= ramstore;
  end

  // ---------------- checking / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [34:0] exp_q[$];  // {check_data, kind(0=data,1=ic0,2=ic1), data}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic chk, input logic [1:0] kind, input logic [31:0] data);
    exp_q.push_back({chk, kind, data});
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [31:0] val);
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(kind) + 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(kind), 32'(e[33:32]));
      if (e[34]) check("sb_data", val, e[31:0]);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      if (!bus_dwait) pop_cmp(2'd0, bus_dload);
      for (int n = 0; n < 2; n++) if (!iwait[n]) pop_cmp(2'(n + 1), iload);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic idle_all();
    bus_dREN = 1'b0; bus_dWEN = 1'b0; bus_daddr = '0; bus_dstore = '0;
    iREN = 2'b00; iaddr[0] = '0; iaddr[1] = '0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  int  wen_n, ren_n, first_wen, dw_low, dw_at, t0, t1, n0, n1, err_n, nc;
  int  scnt_at_i, scnt_after, st3;
  bit  low, low0, low1, after_i;
  logic ren_before, ren_after, dwait_after;
  int  seq [0:7];
  int  seq_exp [0:5];

  initial begin
    idle_all();
    lat = 0; err_mode = 0;
    seq_exp[0] = 0; seq_exp[1] = 0; seq_exp[2] = 0; seq_exp[3] = 0; seq_exp[4] = 2; seq_exp[5] = 0;

    // ---- reset state ----
    repeat (2) @(posedge CLK);
    #1;
    check("rst_dwait", 32'(bus_dwait), 32'd1);
    check("rst_iwait", 32'(iwait), 32'd3);
    check("rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    nRST = 1'b1;
    tick();
    check("rst_state", 32'(dbg_state_o), 32'd0);
    check("rst_rr", 32'(dbg_rr_o), 32'd0);
    check("rst_scnt", 32'(dbg_scnt_o), 32'd0);

    // ---- data write, 2 BUSY cycles, dWEN wins over dREN ----
    lat = 2;
    tick();
    bus_dWEN = 1'b1; bus_dREN = 1'b1; bus_daddr = 32'h100; bus_dstore = 32'hDEADBEEF;
    push_exp(1'b0, 2'd0, 32'd0);
    wen_n = 0; ren_n = 0; first_wen = -1; dw_low = 0; dw_at = -1;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      if (ramWEN) begin wen_n++; if (first_wen < 0) first_wen = j; end
      if (ramREN) ren_n++;
      if (j == 1) begin
        check("wr_ramaddr", ramaddr, 32'h100);
        check("wr_ramstore", ramstore, 32'hDEADBEEF);
      end
      low = !bus_dwait;
      if (low) begin dw_low++; dw_at = j; end
      @(posedge CLK); #1;
      if (low) begin bus_dWEN = 1'b0; bus_dREN = 1'b0; end
    end
    check("wr_wen_cycles", wen_n, 3);
    check("wr_wen_first", first_wen, 1);
    check("wr_no_ren", ren_n, 0);
    check("wr_dwait_pulses", dw_low, 1);
    check("wr_dwait_at", dw_at, 3);
    check("wr_mem", mem[12'h100], 32'hDEADBEEF);

    // ---- both icaches, round robin from rr=0 ----
    lat = 0;
    idle_all();
    tick();
    iREN = 2'b11; iaddr[0] = 32'h0; iaddr[1] = 32'h40;
    push_exp(1'b1, 2'd1, mem[12'h0]);
    push_exp(1'b1, 2'd2, mem[12'h40]);
    t0 = -1; t1 = -1; n0 = 0; n1 = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      low0 = !iwait[0]; low1 = !iwait[1];
      if (low0) begin n0++; if (t0 < 0) t0 = j; end
      if (low1) begin n1++; if (t1 < 0) t1 = j; end
      @(posedge CLK); #1;
      if (low0) iREN[0] = 1'b0;
      if (low1) iREN[1] = 1'b0;
    end
    check("rr_ic0_at", t0, 1);
    check("rr_ic1_at", t1, 3);
    check("rr_ic0_pulses", n0, 1);
    check("rr_ic1_pulses", n1, 1);
    check("rr_final", 32'(dbg_rr_o), 32'd0);

    // ---- starvation guard: data held with icache1 pending ----
    tick();
    bus_dREN = 1'b1; bus_daddr = 32'h200; iREN = 2'b10; iaddr[1] = 32'h300;
    for (int k = 0; k < 4; k++) push_exp(1'b1, 2'd0, mem[12'h200]);
    push_exp(1'b1, 2'd2, mem[12'h300]);
    push_exp(1'b1, 2'd0, mem[12'h200]);
    nc = 0; after_i = 0; scnt_at_i = -1; scnt_after = -1;
    for (int j = 0; j < 40 && nc < 6; j++) begin
      @(negedge CLK);
      if (after_i) begin scnt_after = 32'(dbg_scnt_o); after_i = 0; end
      low = !bus_dwait; low1 = !iwait[1];
      if (low && nc < 8) begin seq[nc] = 0; nc++; end
      if (low1 && nc < 8) begin seq[nc] = 2; nc++; scnt_at_i = 32'(dbg_scnt_o); after_i = 1; end
      if (!iwait[0] && nc < 8) begin seq[nc] = 1; nc++; end
      @(posedge CLK); #1;
      if (low1) iREN[1] = 1'b0;
      if (nc >= 6) bus_dREN = 1'b0;
    end
    check("starve_count", nc, 6);
    for (int k = 0; k < 6; k++) check($sformatf("starve_seq%0d", k), seq[k], seq_exp[k]);
    check("starve_scnt_at_fetch", scnt_at_i, 4);
    check("starve_scnt_after", scnt_after, 0);

    // ---- abort: data drops during BUSY, pending icache0 served next ----
    idle_all();
    lat = 10;
    tick();
    bus_dREN = 1'b1; bus_daddr = 32'h400; iREN = 2'b01; iaddr[0] = 32'h500;
    push_exp(1'b1, 2'd1, mem[12'h500]);
    dw_low = 0; t0 = -1; st3 = -1; ren_before = 1'b0; ren_after = 1'b1; dwait_after = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      if (!bus_dwait) dw_low++;
      if (j == 1) ren_before = ramREN;
      if (j == 3) st3 = 32'(dbg_state_o);
      low0 = !iwait[0];
      if (low0 && t0 < 0) t0 = j;
      @(posedge CLK); #1;
      if (j == 1) begin
        bus_dREN = 1'b0;
        lat = 0;
        #1;
        ren_after = ramREN;
        dwait_after = bus_dwait;
      end
      if (low0) iREN[0] = 1'b0;
    end
    check("abort_ren_before", 32'(ren_before), 32'd1);
    check("abort_ren_after", 32'(ren_after), 32'd0);
    check("abort_dwait_after", 32'(dwait_after), 32'd1);
    check("abort_no_dwait", dw_low, 0);
    check("abort_state_idle", st3, 0);
    check("abort_ic0_at", t0, 4);
    check("abort_scnt", 32'(dbg_scnt_o), 32'd0);
    check("abort_rr", 32'(dbg_rr_o), 32'd1);

    // ---- ERROR retried, then ACCESS ----
    lat = 5; err_mode = 1;
    tick();
    iREN = 2'b01; iaddr[0] = 32'h80;
    push_exp(1'b1, 2'd1, mem[12'h80]);
    ren_n = 0; n0 = 0; t0 = -1; err_n = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge CLK);
      if (ramREN) ren_n++;
      if (ramstate == R_ERR) err_n++;
      low0 = !iwait[0];
      if (low0) begin
        n0++; t0 = j;
        check("err_iload_ramload", iload, ramload);
      end
      @(posedge CLK); #1;
      if (low0) iREN[0] = 1'b0;
    end
    err_mode = 0;
    check("err_ren_cycles", ren_n, 6);
    check("err_err_cycles", err_n, 5);
    check("err_iwait_pulses", n0, 1);
    check("err_iwait_at", t0, 6);

    // ---- reset asserted mid-DATA write ----
    lat = 0;
    tick();
    bus_dREN = 1'b1; bus_daddr = 32'h600; iREN = 2'b10; iaddr[1] = 32'h700;
    push_exp(1'b1, 2'd0, mem[12'h600]);
    @(negedge CLK);
    @(negedge CLK);
    check("mid_pre_dwait", 32'(bus_dwait), 32'd0);
    @(posedge CLK); #1;
    bus_dREN = 1'b0; bus_dWEN = 1'b1; bus_daddr = 32'h640; bus_dstore = 32'h12345678; lat = 10;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_wen", 32'(ramWEN), 32'd1);
    check("mid_scnt", 32'(dbg_scnt_o), 32'd1);
    #1 nRST = 1'b0;
    #1;
    check("mid_rst_wen", 32'(ramWEN), 32'd0);
    check("mid_rst_dwait", 32'(bus_dwait), 32'd1);
    check("mid_rst_iwait", 32'(iwait), 32'd3);
    check("mid_rst_ramaddr", ramaddr, 32'd0);
    idle_all();
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst_state", 32'(dbg_state_o), 32'd0);
    check("post_rst_rr", 32'(dbg_rr_o), 32'd0);
    check("post_rst_scnt", 32'(dbg_scnt_o), 32'd0);
    check("post_rst_mem", mem[12'h640], 32'hC0DE_0000 ^ (32'h640 * 32'h0001_0003));

    repeat (3) @(posedge CLK);
    check("sb_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
